maxpool_relu_stream: RTL

MAXPOOL_RELU_STREAM -- requirements
Module: maxpool_relu_stream

---
 rtl/maxpool_relu_stream.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/maxpool_relu_stream.sv
// 2x2 stride-2 max pooling with fused ReLU over a raster-order conv sample stream.
// One pooled sample is produced per accepted odd-row/odd-column input; a single
// output register gives one-cycle latency, and input is stalled while it is full
// and not being drained.
module maxpool_relu_stream #(
    parameter int unsigned IN_W   = 24,
    parameter int unsigned IN_H   = 24,
    parameter int unsigned DATA_W = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    // Column counter keeps at least two bits so col[COL_W-1:1] is a legal line buffer index.
    localparam int unsigned COL_W = ($clog2(IN_W) < 2) ? 2 : $clog2(IN_W);
    localparam int unsigned ROW_W = ($clog2(IN_H) < 1) ? 1 : $clog2(IN_H);
    localparam int unsigned LB_D  = IN_W / 2;
    localparam int unsigned IDX_W = COL_W - 1;

    typedef logic signed [DATA_W-1:0] sample_t;

    localparam sample_t ZERO = '0;

    // Signed maximum; ties return the shared value, full range compares without overflow.
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    sample_t           pair_q, pair_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              last_q, last_d;

    sample_t           line_buf_q [LB_D];
    logic              lb_we;
    logic [IDX_W-1:0]  lb_idx;
    sample_t           lb_rd;
    sample_t           lb_wdata;

    logic              in_hs;
    logic              out_hs;
    logic              col_wrap;
    logic              row_wrap;
    logic              win_last;
    sample_t           sample;
    sample_t           pair_max;
    sample_t           pool_val;

    // Handshakes and the stall rule: accept input whenever the output slot is free or draining.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        in_hs    = in_valid && in_ready;
        out_hs   = out_valid_q && out_ready;
    end

    // Position decode and datapath: horizontal pair max for even rows, full window max with ReLU for odd rows.
    always_comb begin
        sample   = sample_t'(in_data);
        col_wrap = (col_q == COL_W'(IN_W - 1));
        row_wrap = (row_q == ROW_W'(IN_H - 1));
        win_last = col_wrap && row_wrap;
        lb_idx   = col_q[COL_W-1:1];
        lb_rd    = line_buf_q[lb_idx];
        pair_max = smax(pair_q, sample);
        pool_val = smax(pair_max, smax(lb_rd, ZERO));
        lb_wdata = pair_max;
    end

    // Next-state: raster counters, pair register, line buffer write enable, output slot.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        lb_we       = 1'b0;

        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (in_hs) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : ROW_W'(row_q + ROW_W'(1));
            end else begin
                col_d = COL_W'(col_q + COL_W'(1));
            end

            unique case ({row_q[0], col_q[0]})
                2'b00, 2'b10: pair_d = sample;
                2'b01:        lb_we  = 1'b1;
                2'b11: begin
                    out_data_d  = pool_val;
                    out_valid_d = 1'b1;
                    last_d      = win_last;
                end
                default: ;
            endcase
        end
    end

    // Control and output registers, cleared asynchronously so a reset drops any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            last_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
        end
    end

    // Line buffer of even-row pair maxima; contents are always rewritten before use, so no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf_q[lb_idx] <= lb_wdata;
        end
    end

    // Output drive; frame_done marks the handshake of the frame's final pooled sample.
    always_comb begin
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        frame_done = out_valid_q && out_ready && last_q;
    end

endmodule
